// File: rtl/rv32i_fetch_stage.sv
// RV32I fetch stage: holds the PC, fetches one instruction at a time over imem, and hands it to decode.
// Define RV32I_FETCH_PREDICT_EN to predict JAL and backward branches as taken.
module rv32i_fetch_stage #(
  parameter int unsigned          WORD_SIZE         = 32,
  parameter int unsigned          INSTRUCTION_WIDTH = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC          = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_imem_req_valid,
  input  logic                         i_imem_req_ready,
  output logic [WORD_SIZE-1:0]         o_imem_addr,
  input  logic                         i_imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rsp_data,
  input  logic                         i_branch_mispredict,
  input  logic [WORD_SIZE-1:0]         i_branch_target,
  input  logic                         i_decode_ready,
  output logic                         o_fetch_valid,
  output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
  output logic [WORD_SIZE-1:0]         o_fetch_pc,
  output logic                         o_branch_taken,
  output logic                         o_flush
);

  typedef enum logic [1:0] {StReq, StWait, StValid} state_e;

  state_e                       state_q;
  logic [WORD_SIZE-1:0]         pc_q;
  logic [WORD_SIZE-1:0]         next_pc_q;
  logic [WORD_SIZE-1:0]         fetch_pc_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic                         req_valid_q;
  logic                         fetch_valid_q;
  logic                         taken_q;
  logic                         flush_q;
  logic                         drop_q;

  logic [WORD_SIZE-1:0]         redirect_pc;
  logic [WORD_SIZE-1:0]         pred_pc;
  logic                         pred_taken;
  logic                         unused_target_bits;

  assign redirect_pc        = {i_branch_target[WORD_SIZE-1:2], 2'b00};
  assign unused_target_bits = ^i_branch_target[1:0];

`ifdef RV32I_FETCH_PREDICT_EN
  logic [6:0]  opcode;
  logic [20:0] j_imm;
  logic [12:0] b_imm;

  assign opcode = i_imem_rsp_data[6:0];
  assign j_imm  = {i_imem_rsp_data[31], i_imem_rsp_data[19:12], i_imem_rsp_data[20],
                   i_imem_rsp_data[30:21], 1'b0};
  assign b_imm  = {i_imem_rsp_data[31], i_imem_rsp_data[7], i_imem_rsp_data[30:25],
                   i_imem_rsp_data[11:8], 1'b0};

  // Backward branches (negative offset) and JAL are predicted taken; JALR is not.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc_q + WORD_SIZE'(4);
    if (opcode == 7'b1101111) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + {{(WORD_SIZE-21){j_imm[20]}}, j_imm};
    end else if (opcode == 7'b1100011 && b_imm[12]) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + {{(WORD_SIZE-13){b_imm[12]}}, b_imm};
    end
  end
`else
  assign pred_taken = 1'b0;
  assign pred_pc    = pc_q + WORD_SIZE'(4);
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      next_pc_q     <= '0;
      fetch_pc_q    <= '0;
      instr_q       <= '0;
      req_valid_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      taken_q       <= 1'b0;
      flush_q       <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      flush_q <= i_branch_mispredict;
      if (i_branch_mispredict) begin
        // Redirect wins over any handshake; an in-flight response is marked for discard.
        pc_q          <= redirect_pc;
        fetch_valid_q <= 1'b0;
        unique case (state_q)
          StReq: begin
            if (req_valid_q && i_imem_req_ready) begin
              state_q     <= StWait;
              req_valid_q <= 1'b0;
              drop_q      <= 1'b1;
            end else begin
              req_valid_q <= 1'b1;
            end
          end
          StWait: begin
            if (i_imem_rsp_valid) begin
              state_q     <= StReq;
              req_valid_q <= 1'b1;
              drop_q      <= 1'b0;
            end else begin
              drop_q <= 1'b1;
            end
          end
          StValid: begin
            state_q     <= StReq;
            req_valid_q <= 1'b1;
          end
          default: state_q <= StReq;
        endcase
      end else begin
        unique case (state_q)
          StReq: begin
            if (req_valid_q && i_imem_req_ready) begin
              state_q     <= StWait;
              req_valid_q <= 1'b0;
            end else begin
              req_valid_q <= 1'b1;
            end
          end
          StWait: begin
            if (i_imem_rsp_valid) begin
              if (drop_q) begin
                drop_q      <= 1'b0;
                state_q     <= StReq;
                req_valid_q <= 1'b1;
              end else begin
                instr_q       <= i_imem_rsp_data;
                fetch_pc_q    <= pc_q;
                next_pc_q     <= pred_pc;
                taken_q       <= pred_taken;
                fetch_valid_q <= 1'b1;
                state_q       <= StValid;
              end
            end
          end
          StValid: begin
            if (i_decode_ready) begin
              pc_q          <= next_pc_q;
              fetch_valid_q <= 1'b0;
              state_q       <= StReq;
              req_valid_q   <= 1'b1;
            end
          end
          default: state_q <= StReq;
        endcase
      end
    end
  end

  assign o_imem_req_valid    = req_valid_q;
  assign o_imem_addr         = pc_q;
  assign o_fetch_valid       = fetch_valid_q;
  assign o_fetch_instruction = instr_q;
  assign o_fetch_pc          = fetch_pc_q;
  assign o_branch_taken      = taken_q;
  assign o_flush             = flush_q;

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Bench for rv32i_fetch_stage: scripted corner cases, then random imem/decode/redirect traffic
// checked against a program-level model of the expected fetch sequence.
module tb_rv32i_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          CYCLES   = 4000;
  localparam int          NSC      = 7;
  localparam int          KValid   = 0;
  localparam int          KWait    = 1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_branch_mispredict;
  logic [31:0] i_branch_target;
  logic        i_decode_ready;
  logic        o_fetch_valid;
  logic [31:0] o_fetch_instruction;
  logic [31:0] o_fetch_pc;
  logic        o_branch_taken;
  logic        o_flush;

  rv32i_fetch_stage #(
    .WORD_SIZE        (32),
    .INSTRUCTION_WIDTH(32),
    .RESET_PC         (RESET_PC)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .o_imem_req_valid   (o_imem_req_valid),
    .i_imem_req_ready   (i_imem_req_ready),
    .o_imem_addr        (o_imem_addr),
    .i_imem_rsp_valid   (i_imem_rsp_valid),
    .i_imem_rsp_data    (i_imem_rsp_data),
    .i_branch_mispredict(i_branch_mispredict),
    .i_branch_target    (i_branch_target),
    .i_decode_ready     (i_decode_ready),
    .o_fetch_valid      (o_fetch_valid),
    .o_fetch_instruction(o_fetch_instruction),
    .o_fetch_pc         (o_fetch_pc),
    .o_branch_taken     (o_branch_taken),
    .o_flush            (o_flush)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Program image: instruction word, expected successor address and prediction per address.
  logic [31:0] mem_ins [logic [31:0]];
  logic [31:0] mem_nxt [logic [31:0]];
  logic        mem_tk  [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // kind: 0 ALU-imm, 1 JAL, 2 conditional branch, 3 JALR; imm is the byte offset.
  task automatic gen_at(input logic [31:0] a, input int kind, input int imm);
    logic [31:0] r, iv, ins;
    logic        tk;
    r  = $urandom();
    iv = imm;
    case (kind)
      1:       ins = {iv[20], iv[10:1], iv[11], iv[19:12], r[4:0], 7'b1101111};
      2:       ins = {iv[12], iv[10:5], r[9:5], r[14:10], r[17:15], iv[4:1], iv[11], 7'b1100011};
      3:       ins = {r[24:0], 7'b1100111};
      default: ins = {r[24:0], 7'b0010011};
    endcase
`ifdef RV32I_FETCH_PREDICT_EN
    tk = (kind == 1) || (kind == 2 && imm < 0);
`else
    tk = 1'b0;
`endif
    mem_ins[a] = ins;
    mem_tk[a]  = tk;
    mem_nxt[a] = tk ? a + iv : a + 32'd4;
  endtask

  task automatic ensure(input logic [31:0] a);
    int kind, imm;
    if (!mem_ins.exists(a)) begin
      kind = int'($urandom_range(0, 3));
      imm  = 0;
      if (kind == 1) imm = int'($urandom_range(0, 1048575)) * 2 - 1048576;
      else if (kind == 2) imm = int'($urandom_range(0, 4095)) * 2 - 4096;
      gen_at(a, kind, imm);
    end
  endtask

  int          sc_kind [NSC];
  int          sc_skip [NSC];
  logic [31:0] sc_tgt  [NSC];
  int          sc_idx;

  logic        s_req, s_fv, s_tk, s_flush;
  logic [31:0] s_addr, s_ins, s_pc;
  logic        p_mis, p_hold, p_reqwait, p_tk;
  logic [31:0] p_addr, p_ins, p_pc;
  logic        req_rdy, dec_rdy, mis, rsp_v, pending, just_acc;
  logic [31:0] tgt, exp_pc, pend_addr;
  int          cnt, lat, hold_left, n_hs;

  initial begin
    sc_kind = '{KValid, KValid, KValid, KValid, KWait, KValid, KValid};
    sc_skip = '{1, 1, 1, 0, 0, 0, 1};
    sc_tgt  = '{32'h200, 32'h300, 32'h300, 32'h80, 32'h400, 32'hFFFF_FFFC, 32'h403};
    gen_at(32'h100, 0, 0);
    gen_at(32'h104, 0, 0);
    gen_at(32'h200, 2, -16);
    gen_at(32'h300, 1, 64);
    gen_at(32'hFFFF_FFFC, 0, 0);

    i_rst = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = '0;
    i_branch_mispredict = 1'b0;
    i_branch_target = '0;
    i_decode_ready = 1'b0;
    sc_idx = 0; hold_left = 5; n_hs = 0;
    pending = 1'b0; just_acc = 1'b0; cnt = 0;
    p_mis = 1'b0; p_hold = 1'b0; p_reqwait = 1'b0; p_tk = 1'b0;
    p_addr = '0; p_ins = '0; p_pc = '0;
    exp_pc = RESET_PC;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_req_valid", o_imem_req_valid, 0);
    check("rst_addr", o_imem_addr, RESET_PC);
    check("rst_fetch_valid", o_fetch_valid, 0);
    check("rst_fetch_pc", o_fetch_pc, 0);
    check("rst_instr", o_fetch_instruction, 0);
    check("rst_taken", o_branch_taken, 0);
    check("rst_flush", o_flush, 0);
    i_rst = 1'b1;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      if (cyc > 0) @(negedge i_clk);
      s_req = o_imem_req_valid; s_addr = o_imem_addr; s_fv = o_fetch_valid;
      s_ins = o_fetch_instruction; s_pc = o_fetch_pc; s_tk = o_branch_taken; s_flush = o_flush;

      check("flush", s_flush, p_mis);
      if (p_mis) check("valid_after_redirect", s_fv, 0);
      if (p_hold) begin
        check("hold_valid", s_fv, 1);
        check("hold_pc", s_pc, p_pc);
        check("hold_instr", s_ins, p_ins);
        check("hold_taken", s_tk, p_tk);
        check("hold_no_req", s_req, 0);
      end
      if (p_reqwait) begin
        check("req_held", s_req, 1);
        check("addr_held", s_addr, p_addr);
      end
      if (cyc == 0) check("no_req_in_release_cycle", s_req, 0);
      if (cyc == 1) begin
        check("first_req", s_req, 1);
        check("first_addr", s_addr, RESET_PC);
      end
      if (cyc == 3) check("first_valid", s_fv, 1);

      rsp_v = pending && cnt == 1;
      if (pending) begin
        if (cnt == 1) pending = 1'b0;
        else cnt--;
      end

      mis = 1'b0;
      tgt = $urandom();
      if (sc_idx < NSC) begin
        req_rdy = 1'b1;
        dec_rdy = 1'b1;
        if (s_fv && hold_left > 0) begin
          dec_rdy = 1'b0;
          hold_left--;
        end else if (sc_kind[sc_idx] == KValid && s_fv) begin
          if (sc_skip[sc_idx] > 0) sc_skip[sc_idx]--;
          else begin mis = 1'b1; tgt = sc_tgt[sc_idx]; sc_idx++; end
        end else if (sc_kind[sc_idx] == KWait && just_acc) begin
          mis = 1'b1; tgt = sc_tgt[sc_idx]; sc_idx++;
        end
      end else begin
        req_rdy = $urandom_range(0, 3) != 0;
        dec_rdy = $urandom_range(0, 3) != 0;
        mis     = $urandom_range(0, 15) == 0;
      end

      i_imem_req_ready    = req_rdy;
      i_imem_rsp_valid    = rsp_v;
      i_imem_rsp_data     = rsp_v ? mem_ins[pend_addr] : $urandom();
      i_decode_ready      = dec_rdy;
      i_branch_mispredict = mis;
      i_branch_target     = tgt;

      if (s_req && req_rdy) begin
        check("req_addr", s_addr, exp_pc);
        ensure(s_addr);
        if (sc_idx < NSC) lat = (sc_kind[sc_idx] == KWait) ? 3 : 1;
        else lat = int'($urandom_range(1, 3));
        pending = 1'b1; cnt = lat; pend_addr = s_addr; just_acc = 1'b1;
      end else begin
        just_acc = 1'b0;
      end

      if (s_fv && dec_rdy && !mis) begin
        ensure(exp_pc);
        check("fetch_pc", s_pc, exp_pc);
        check("fetch_instr", s_ins, mem_ins[exp_pc]);
        check("fetch_taken", s_tk, mem_tk[exp_pc]);
        exp_pc = mem_nxt[exp_pc];
        n_hs++;
      end
      if (mis) exp_pc = {tgt[31:2], 2'b00};

      p_mis     = mis;
      p_hold    = s_fv && !dec_rdy && !mis;
      p_reqwait = s_req && !req_rdy && !mis;
      p_addr = s_addr; p_ins = s_ins; p_pc = s_pc; p_tk = s_tk;
    end

    check("script_done", sc_idx, NSC);
    check("progress", n_hs > 200, 1);

    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("midrun_rst_req", o_imem_req_valid, 0);
    check("midrun_rst_valid", o_fetch_valid, 0);
    check("midrun_rst_addr", o_imem_addr, RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
